// File: rtl/cv32e40p_pkg.sv
// Shared types for the instruction prefetch path.
package cv32e40p_pkg;

  // Request-side FSM of the prefetch controller.
  typedef enum logic [0:0] {
    IDLE        = 1'b0,
    BRANCH_WAIT = 1'b1
  } prefetch_state_e;

  // Width of a fetched word as stored in the FIFO: {err, rdata}.
  localparam int unsigned FETCH_W = 33;

endpackage

// File: rtl/instr_prefetch_ctrl.sv
// Instruction-fetch transaction controller sitting in front of the prefetch FIFO.
// Issues word-aligned bus requests, counts outstanding ones, routes responses
// either straight to the aligner (bypass) or into the FIFO, and discards stale
// responses after a branch.
//
// Handshakes: a bus request transfers when trans_valid_o & trans_ready_i; once
// raised, trans_valid_o and trans_addr_o stay stable until that transfer.
// Responses (resp_valid_i) are always accepted. A fetch word transfers to the
// aligner when fetch_valid_o & fetch_ready_i.
module instr_prefetch_ctrl
  import cv32e40p_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  input  logic               branch_i,
  input  logic [31:0]        branch_addr_i,
  output logic               busy_o,
  output logic               trans_valid_o,
  input  logic               trans_ready_i,
  output logic [31:0]        trans_addr_o,
  input  logic               resp_valid_i,
  input  logic [31:0]        resp_rdata_i,
  input  logic               resp_err_i,
  output logic               fifo_push_o,
  output logic [FETCH_W-1:0] fifo_wdata_o,
  output logic               fifo_flush_o,
  output logic               fifo_pop_o,
  input  logic [CNT_W-1:0]   fifo_cnt_i,
  input  logic               fifo_empty_i,
  input  logic [FETCH_W-1:0] fifo_rdata_i,
  output logic               fetch_valid_o,
  input  logic               fetch_ready_i,
  output logic [31:0]        fetch_rdata_o,
  output logic               fetch_err_o
);

  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;
  localparam logic [OUT_W-1:0] MAX_OUT_C = OUT_W'(MAX_OUTSTANDING);
  localparam logic [SUM_W-1:0] DEPTH_C   = SUM_W'(DEPTH);

  prefetch_state_e    r_state;
  prefetch_state_e    w_state_nxt;
  logic [31:0]        r_addr;
  logic [31:0]        r_hold_addr;
  logic [OUT_W-1:0]   r_cnt;
  logic [OUT_W-1:0]   r_flush_cnt;

  logic               w_run;
  logic [SUM_W-1:0]   w_sum;
  logic               w_issue;
  logic               w_trans_valid;
  logic [31:0]        w_trans_addr;
  logic               w_stale;
  logic               w_accept;
  logic               w_stale_acc;
  logic               w_resp_live;
  logic               w_deliver;
  logic               w_bypass;
  logic               w_push;
  logic [FETCH_W-1:0] w_resp_word;
  logic [FETCH_W-1:0] w_fetch_word;

  // Reset forces every output low regardless of the inputs.
  assign w_run = ~rst_i;

  // Room for another request: outstanding limit and FIFO space for its word.
  assign w_sum   = SUM_W'(r_cnt) + SUM_W'(fifo_cnt_i);
  assign w_issue = req_i & (r_cnt < MAX_OUT_C) & (w_sum < DEPTH_C);

  // Request FSM: IDLE issues freely; BRANCH_WAIT holds a pre-branch request until it is taken.
  always_comb begin
    w_state_nxt   = r_state;
    w_trans_valid = 1'b0;
    w_trans_addr  = {r_addr[31:2], 2'b00};
    w_stale       = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_trans_valid = w_issue;
        w_stale       = branch_i;
        if (branch_i & w_issue & ~trans_ready_i) begin
          w_state_nxt = BRANCH_WAIT;
        end
      end
      BRANCH_WAIT: begin
        w_trans_valid = 1'b1;
        w_trans_addr  = r_hold_addr;
        w_stale       = 1'b1;
        if (trans_ready_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept    = w_run & w_trans_valid & trans_ready_i;
  assign w_stale_acc = w_accept & w_stale;

  // A response only counts while something is outstanding; this also drops
  // late responses to requests issued before a reset.
  assign w_resp_live = resp_valid_i & (r_cnt != '0);
  assign w_deliver   = w_resp_live & (r_flush_cnt == '0) & ~branch_i;
  assign w_bypass    = w_deliver & fifo_empty_i & fetch_ready_i;
  assign w_push      = w_deliver & ~w_bypass;

  assign w_resp_word  = {resp_err_i, resp_rdata_i};
  assign w_fetch_word = fifo_empty_i ? w_resp_word : fifo_rdata_i;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next fetch address: jump on branch, advance one word on a normal accept.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_addr <= '0;
    end else if (branch_i) begin
      r_addr <= {branch_addr_i[31:2], 2'b00};
    end else if (w_accept & (r_state == IDLE)) begin
      r_addr <= r_addr + 32'd4;
    end
  end

  // Capture the request that was pending when the branch arrived.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_hold_addr <= '0;
    end else if ((r_state == IDLE) & branch_i) begin
      r_hold_addr <= w_trans_addr;
    end
  end

  // Outstanding-request counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + OUT_W'(w_accept) - OUT_W'(w_resp_live);
    end
  end

  // Number of in-flight responses still to be thrown away after a branch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_flush_cnt <= '0;
    end else if (branch_i) begin
      r_flush_cnt <= r_cnt - OUT_W'(w_resp_live) + OUT_W'(w_stale_acc);
    end else begin
      r_flush_cnt <= r_flush_cnt - OUT_W'(w_resp_live & (r_flush_cnt != '0))
                     + OUT_W'(w_stale_acc);
    end
  end

  assign trans_valid_o = w_run & w_trans_valid;
  assign trans_addr_o  = w_run ? w_trans_addr : 32'd0;
  assign busy_o        = w_run & ((r_cnt != '0) | w_trans_valid);
  assign fifo_push_o   = w_run & w_push;
  assign fifo_wdata_o  = w_run ? w_resp_word : '0;
  assign fifo_flush_o  = w_run & branch_i;
  assign fifo_pop_o    = w_run & fetch_ready_i & ~fifo_empty_i & ~branch_i;
  assign fetch_valid_o = w_run & (~fifo_empty_i | w_bypass) & ~branch_i;
  assign fetch_rdata_o = w_run ? w_fetch_word[31:0] : 32'd0;
  assign fetch_err_o   = w_run & w_fetch_word[FETCH_W-1];

  a_resp_needs_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    resp_valid_i |-> (r_cnt != '0));
  a_cnt_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
    r_cnt <= MAX_OUT_C);

endmodule
